// File: rtl/par2serial_tx.sv
// Byte-to-serial transmit stage: MSB-first, COM (8'hBC) filler, SYNC training run after reset.
// Optional accepted-byte counter output frame_cnt enabled by PAR2SER_FRAME_CNT_EN.
module par2serial_tx #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COM_BYTE   = 8'hBC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready,
  output logic       data_out,
  output logic       synced
`ifdef PAR2SER_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned CW = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e          state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shreg_q;
  logic [CW-1:0]   com_cnt_q;
  logic            data_out_q;
  logic            synced_q;
  logic            frame_end;
  logic            accept;

  assign frame_end = (bit_cnt_q == 3'd7);
  assign ready     = (state_q == ACTIVE) && frame_end;
  assign accept    = ready && valid_in;
  assign data_out  = data_out_q;
  assign synced    = synced_q;

  // Serialiser and SYNC->ACTIVE sequencing; ~bit_cnt_q selects bit 7-bit_cnt (MSB first).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= COM_BYTE;
      com_cnt_q  <= '0;
      data_out_q <= 1'b0;
      synced_q   <= 1'b0;
    end else begin
      data_out_q <= shreg_q[~bit_cnt_q];
      bit_cnt_q  <= bit_cnt_q + 3'd1;
      if (frame_end) begin
        shreg_q <= accept ? data_in : COM_BYTE;
        if (state_q == SYNC) begin
          com_cnt_q <= com_cnt_q + CW'(1);
          if (com_cnt_q == CW'(SYNC_COUNT - 1)) begin
            state_q  <= ACTIVE;
            synced_q <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PAR2SER_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Counts accepted data bytes only; COM filler frames are never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 8'd0;
    end else if (accept) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  // Counter absent in this build; serial path is unaffected.
`endif

endmodule

// File: tb/tb_par2serial_tx.sv
// Directed bench for par2serial_tx: reset, SYNC run, table of ACTIVE frames, mid-byte reset,
// and (with PAR2SER_FRAME_CNT_EN) frame counter wrap.
module tb_par2serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;
  logic       data_out;
  logic       synced;
`ifdef PAR2SER_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic [7:0] exp_ser;
    logic [7:0] exp_fc;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  par2serial_tx dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready    (ready),
    .data_out (data_out),
    .synced   (synced)
`ifdef PAR2SER_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fc(input string name, input logic [7:0] exp);
`ifdef PAR2SER_FRAME_CNT_EN
    chk8(name, frame_cnt, exp);
`endif
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    for (int i = 0; i < n; i++) begin
      tick();
      chk1("rst_data_out", data_out, 1'b0);
      chk1("rst_ready", ready, 1'b0);
      chk1("rst_synced", synced, 1'b0);
      chk_fc("rst_frame_cnt", 8'd0);
    end
    reset    = 1'b0;
    valid_in = 1'b0;
  endtask

  // Edges 1..39 after reset release; leaves the bench just before edge 40 with ready expected high.
  task automatic sync_run();
    logic [7:0] com;
    int         idx;
    com = 8'hBC;
    for (int k = 1; k <= 39; k++) begin
      chk1("sync_ready_low", ready, 1'b0);
      tick();
      idx = 7 - ((k - 1) % 8);
      chk1("sync_bit", data_out, com[idx]);
      chk1("sync_synced", synced, k >= 32);
    end
    chk1("sync_ready_first", ready, 1'b1);
  endtask

  initial begin
    logic [7:0] got;

    tbl[0] = '{1'b1, 8'hA5, 8'hA5, 8'd1};
    tbl[1] = '{1'b1, 8'h3C, 8'h3C, 8'd2};
    tbl[2] = '{1'b0, 8'h77, 8'hBC, 8'd2};
    tbl[3] = '{1'b1, 8'hFF, 8'hFF, 8'd3};
    tbl[4] = '{1'b1, 8'hBC, 8'hBC, 8'd4};
    tbl[5] = '{1'b0, 8'h00, 8'hBC, 8'd4};
    tbl[6] = '{1'b1, 8'h00, 8'h00, 8'd5};
    tbl[7] = '{1'b1, 8'h5A, 8'h5A, 8'd6};

    do_reset(3);
    sync_run();

    // Edge 40 accepts tbl[0]; its own output bit is the COM LSB.
    valid_in = tbl[0].vin;
    data_in  = tbl[0].din;
    tick();
    chk1("com_lsb", data_out, 1'b0);
    chk_fc("fc_first", tbl[0].exp_fc);

    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (b == 7) begin
          if (i < 7) begin
            valid_in = tbl[i+1].vin;
            data_in  = tbl[i+1].din;
          end else begin
            valid_in = 1'b0;
          end
          chk1("act_ready_high", ready, 1'b1);
        end else begin
          // Garbage offered while ready is low must be ignored.
          valid_in = 1'b1;
          data_in  = 8'($urandom);
          chk1("act_ready_low", ready, 1'b0);
        end
        tick();
        got[7-b] = data_out;
      end
      chk8("ser_byte", got, tbl[i].exp_ser);
      chk1("act_synced", synced, 1'b1);
      if (i < 7) chk_fc("fc_table", tbl[i+1].exp_fc);
    end

    // Mid-byte reset: accept C3 at edge 40, reset on edge 44.
    do_reset(1);
    sync_run();
    valid_in = 1'b1;
    data_in  = 8'hC3;
    tick();
    valid_in = 1'b0;
    tick();
    chk1("mid_bit41", data_out, 1'b1);
    tick();
    chk1("mid_bit42", data_out, 1'b1);
    tick();
    chk1("mid_bit43", data_out, 1'b0);
    chk_fc("mid_fc_pre", 8'd1);
    reset = 1'b1;
    tick();
    chk1("mid_rst_data_out", data_out, 1'b0);
    chk1("mid_rst_synced", synced, 1'b0);
    chk1("mid_rst_ready", ready, 1'b0);
    chk_fc("mid_rst_fc", 8'd0);
    reset = 1'b0;
    sync_run();
    tick();
    got = '0;
    for (int b = 0; b < 8; b++) begin
      tick();
      got[7-b] = data_out;
    end
    chk8("post_reset_filler", got, 8'hBC);

`ifdef PAR2SER_FRAME_CNT_EN
    do_reset(1);
    sync_run();
    valid_in = 1'b1;
    data_in  = 8'h11;
    for (int n = 1; n <= 257; n++) begin
      chk1("wrap_ready", ready, 1'b1);
      tick();
      if (n == 255) chk8("fc_wrap_255", frame_cnt, 8'd255);
      if (n == 256) chk8("fc_wrap_0", frame_cnt, 8'd0);
      if (n == 257) chk8("fc_wrap_1", frame_cnt, 8'd1);
      repeat (7) tick();
    end
    valid_in = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
